// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: default geometry, half-enable
// encodings and a constant-foldable clog2 for sizing address ports.
package register_bank_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  localparam logic [1:0] HALF_NONE = 2'b00;
  localparam logic [1:0] HALF_LO   = 2'b01;
  localparam logic [1:0] HALF_HI   = 2'b10;
  localparam logic [1:0] HALF_ALL  = 2'b11;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/register_half_cell.sv
// Single WIDTH-bit register whose low and high halves load independently,
// cleared asynchronously while res is low.
module register_half_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic [1:0]       en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int H = WIDTH / 2;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q <= '0;
    end else begin
      if (en[0]) q[H-1:0]     <= d[H-1:0];
      if (en[1]) q[WIDTH-1:H] <= d[WIDTH-1:H];
    end
  end

endmodule

// File: rtl/register_bank.sv
// General-purpose register file with half-granular writes, two registered
// read ports that see same-cycle writes, and a per-register pending scoreboard.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       whalf,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy_a,
  output logic             busy_b
);

  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic             eff_we;
  logic             eff_pend;
  logic [WIDTH-1:0] nxt_a;
  logic [WIDTH-1:0] nxt_b;

  // Register 0 is hardwired to zero when ZERO_REG is set, so writes and
  // pending marks aimed at it are dropped before they reach any state.
  assign eff_we   = we && (whalf != HALF_NONE) && !(ZERO_REG && (waddr == '0));
  assign eff_pend = pend_set && !(ZERO_REG && (pend_addr == '0));

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic [1:0] cell_en;
    assign cell_en = (eff_we && (waddr == AW'(g))) ? whalf : HALF_NONE;

    register_half_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .res (res),
      .en  (cell_en),
      .d   (wdata),
      .q   (regs[g])
    );
  end

  // Value the addressed register will hold after this edge, merging in
  // whichever halves the concurrent write touches.
  function automatic logic [WIDTH-1:0] forward(
    input logic [WIDTH-1:0] cur,
    input logic [AW-1:0]    ra,
    input logic             wr,
    input logic [AW-1:0]    wa,
    input logic [1:0]       wh,
    input logic [WIDTH-1:0] wd
  );
    logic [WIDTH-1:0] v;
    v = cur;
    if (wr && (wa == ra)) begin
      if (wh[0]) v[H-1:0]     = wd[H-1:0];
      if (wh[1]) v[WIDTH-1:H] = wd[WIDTH-1:H];
    end
    if (ZERO_REG && (ra == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    nxt_a = forward(regs[raddr_a], raddr_a, eff_we, waddr, whalf, wdata);
    nxt_b = forward(regs[raddr_b], raddr_b, eff_we, waddr, whalf, wdata);
  end

  // A new producer issued in the same cycle as the old one's writeback
  // supersedes it, so the set is applied after the clear.
  always_comb begin
    pend_nxt = pend;
    if (eff_we)   pend_nxt[waddr]     = 1'b0;
    if (eff_pend) pend_nxt[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pend    <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
      busy_a  <= 1'b0;
      busy_b  <= 1'b0;
    end else begin
      pend    <= pend_nxt;
      rdata_a <= nxt_a;
      rdata_b <= nxt_b;
      busy_a  <= pend_nxt[raddr_a];
      busy_b  <= pend_nxt[raddr_b];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_register_bank;

  logic       clk;
  logic       res;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [1:0] whalf;
  logic       pend_set;
  logic [2:0] pend_addr;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       busy_a;
  logic       busy_b;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  logic [7:0] m_reg [8];
  logic [7:0] m_pend;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic       exp_busy_a;
  logic       exp_busy_b;

  register_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1)) dut (
    .clk       (clk),
    .res       (res),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .whalf     (whalf),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
    end
  endtask

  // Registers hold whatever was written half by half; register 0 is never
  // written; a register is pending from its last issue until a later write.
  always @(posedge clk or negedge res) begin : model
    logic [7:0] nreg [8];
    logic [7:0] npend;
    if (!res) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 8'h00;
      m_pend     <= 8'h00;
      exp_a      <= 8'h00;
      exp_b      <= 8'h00;
      exp_busy_a <= 1'b0;
      exp_busy_b <= 1'b0;
    end else begin
      nreg  = m_reg;
      npend = m_pend;
      if (we && waddr != 3'd0) begin
        if (whalf[0]) nreg[waddr][3:0] = wdata[3:0];
        if (whalf[1]) nreg[waddr][7:4] = wdata[7:4];
        if (whalf != 2'b00) npend[waddr] = 1'b0;
      end
      if (pend_set && pend_addr != 3'd0) npend[pend_addr] = 1'b1;
      m_reg      <= nreg;
      m_pend     <= npend;
      exp_a      <= nreg[raddr_a];
      exp_b      <= nreg[raddr_b];
      exp_busy_a <= npend[raddr_a];
      exp_busy_b <= npend[raddr_b];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_rdata_a", rdata_a, exp_a);
      checkOutput("model_rdata_b", rdata_b, exp_b);
      checkOutput("model_busy_a", {7'd0, busy_a}, {7'd0, exp_busy_a});
      checkOutput("model_busy_b", {7'd0, busy_b}, {7'd0, exp_busy_b});
    end
  end

  task automatic applyStimulus(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                               input logic [1:0] wh, input logic ps, input logic [2:0] pa,
                               input logic [2:0] ra, input logic [2:0] rb);
    we        = w;
    waddr     = wa;
    wdata     = wd;
    whalf     = wh;
    pend_set  = ps;
    pend_addr = pa;
    raddr_a   = ra;
    raddr_b   = rb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b0;
    we = 1'b1; waddr = 3'd3; wdata = 8'hFF; whalf = 2'b11;
    pend_set = 1'b1; pend_addr = 3'd3; raddr_a = 3'd3; raddr_b = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1;
    checkOutput("reset_rdata_a", rdata_a, 8'h00);
    checkOutput("reset_busy_a", {7'd0, busy_a}, 8'h00);

    res = 1'b1;
    applyStimulus(0, 3'd3, 8'hFF, 2'b11, 0, 3'd0, 3'd3, 3'd2);
    checkOutput("post_reset_rdata_a", rdata_a, 8'h00);
    checkOutput("post_reset_busy_a", {7'd0, busy_a}, 8'h00);

    applyStimulus(1, 3'd3, 8'hA5, 2'b11, 0, 3'd0, 3'd3, 3'd2);
    checkOutput("write_full", rdata_a, 8'hA5);
    applyStimulus(1, 3'd3, 8'h3C, 2'b10, 0, 3'd0, 3'd3, 3'd2);
    checkOutput("write_high_half", rdata_a, 8'h35);

    applyStimulus(1, 3'd2, 8'h7E, 2'b01, 0, 3'd0, 3'd3, 3'd2);
    checkOutput("forward_low_half", rdata_b, 8'h0E);

    applyStimulus(1, 3'd0, 8'hFF, 2'b11, 1, 3'd0, 3'd0, 3'd2);
    checkOutput("zero_reg_data", rdata_a, 8'h00);
    checkOutput("zero_reg_busy", {7'd0, busy_a}, 8'h00);

    applyStimulus(0, 3'd0, 8'h00, 2'b00, 1, 3'd5, 3'd5, 3'd2);
    checkOutput("pend_set_busy", {7'd0, busy_a}, 8'h01);
    applyStimulus(1, 3'd5, 8'h99, 2'b00, 0, 3'd0, 3'd5, 3'd2);
    checkOutput("noop_write_busy", {7'd0, busy_a}, 8'h01);
    applyStimulus(1, 3'd5, 8'h11, 2'b11, 0, 3'd0, 3'd5, 3'd2);
    checkOutput("writeback_busy", {7'd0, busy_a}, 8'h00);
    checkOutput("writeback_data", rdata_a, 8'h11);
    applyStimulus(1, 3'd5, 8'h22, 2'b11, 1, 3'd5, 3'd5, 3'd2);
    checkOutput("set_wins_busy", {7'd0, busy_a}, 8'h01);
    checkOutput("set_wins_data", rdata_a, 8'h22);

    applyStimulus(1, 3'd4, 8'hC3, 2'b11, 0, 3'd0, 3'd4, 3'd4);
    checkOutput("dual_read_a", rdata_a, 8'hC3);
    checkOutput("dual_read_b", rdata_b, 8'hC3);
    applyStimulus(0, 3'd0, 8'h00, 2'b00, 0, 3'd0, 3'd4, 3'd4);
    checkOutput("dual_hold_a", rdata_a, 8'hC3);
    checkOutput("dual_hold_b", rdata_b, 8'hC3);

    // Asynchronous reset lands between edges while a write is pending.
    we = 1'b1; waddr = 3'd4; wdata = 8'h55; whalf = 2'b11;
    pend_set = 1'b1; pend_addr = 3'd4;
    #2;
    res = 1'b0;
    #1;
    checkOutput("async_reset_a", rdata_a, 8'h00);
    checkOutput("async_reset_b", rdata_b, 8'h00);
    @(posedge clk);
    #1;
    res = 1'b1;
    applyStimulus(0, 3'd0, 8'h00, 2'b00, 0, 3'd0, 3'd4, 3'd5);
    checkOutput("reset_discard_data", rdata_a, 8'h00);
    checkOutput("reset_discard_busy", {7'd0, busy_a}, 8'h00);

    for (int n = 0; n < 600; n++) begin
      logic [2:0] ra;
      logic [2:0] rb;
      ra = 3'($urandom_range(7));
      rb = ($urandom_range(3) == 0) ? ra : 3'($urandom_range(7));
      res = ($urandom_range(79) != 0);
      applyStimulus(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom_range(255)),
                    2'($urandom_range(3)), 1'($urandom_range(3) == 0),
                    3'($urandom_range(7)), ra, rb);
    end
    res = 1'b1;
    applyStimulus(0, 3'd0, 8'h00, 2'b00, 0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    #1;
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
